decimate_buffer: RTL and testbench
==================================

DECIMATE_BUFFER -- requirements
Module: decimate_buffer

Interface
REQ-001 The block SHALL have parameter DECIM, default 4, meaning the decimation ratio (legal range 1..256; 1 keeps every sample).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the FIFO depth in samples (power of 2, legal range 2..256).
REQ-003 The block SHALL have parameter SKIP, default 10, meaning the number of input samples discarded after reset while the upstream filter pipeline fills (legal range 0..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port inData, input, signed 16 bits: the filter output sample, valid on every clk cycle.
REQ-007 The block SHALL have port clear_ovf, input, 1 bit: clears overflow and drop_cnt.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer ready.
REQ-009 The block SHALL have port out_data, output, signed 16 bits: the FIFO head sample.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 The block SHALL have port level, output, clog2(DEPTH+1) bits: the current FIFO occupancy.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag set when a decimated sample is dropped.
REQ-013 The block SHALL have port drop_cnt, output, 8 bits: saturating count of dropped samples.

Function
REQ-014 The block SHALL hold a skip counter starting at 0 after reset and SHALL ignore inData on each cycle while the counter is below SKIP, incrementing it each such cycle.
REQ-015 Once skipping completes, a phase counter 0..DECIM-1 SHALL advance once per cycle and wrap from DECIM-1 to 0.
REQ-016 The phase counter SHALL be 0 on the first non-skipped cycle.
REQ-017 inData SHALL be captured as a decimated sample on every non-skipped cycle with phase==0, and on no other cycle.
REQ-018 The FIFO SHALL be first-word-fall-through.
REQ-019 out_valid SHALL equal (level!=0), and out_data SHALL show the oldest stored sample.
REQ-020 A pop SHALL occur on a cycle with out_valid && out_ready; the head advances and level decrements at that edge.
REQ-021 A captured sample SHALL be written when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-022 With a simultaneous write and pop, level SHALL be unchanged.
REQ-023 Write latency: a sample captured at edge t SHALL be visible on out_data with out_valid=1 from cycle t+1 when the FIFO was empty.
REQ-024 When empty, out_ready SHALL have no effect; a capture on the same cycle is simply written.
REQ-025 A captured sample that cannot be written SHALL be dropped: overflow is set to 1 and drop_cnt increments, saturating at 255.
REQ-026 FIFO contents SHALL remain unchanged on a drop.
REQ-027 clear_ovf SHALL zero overflow and drop_cnt at the next edge.
REQ-028 If a drop coincides with clear_ovf, overflow SHALL be 1 and drop_cnt SHALL be 1 after the edge.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 Samples SHALL pass through bit-exact, with no rounding or sign change.
REQ-031 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-032 While reset=1 at an edge, the skip counter, phase counter, both pointers, level, overflow and drop_cnt SHALL clear to 0.
REQ-033 While reset=1 at an edge, out_valid and out_data SHALL clear to 0.
REQ-034 Reset asserted mid-operation SHALL discard all FIFO contents and restart the skip count.
REQ-035 Samples presented during reset SHALL never be captured.
REQ-036 The first cycle after reset deasserts SHALL count as skip cycle 0.

Verification
REQ-037 The bench SHALL cover: defaults, inData=cycle index n starting at 0 after reset, out_ready=1 -> outputs 10,14,18,22... each valid one cycle after its capture, and never 0..9.
REQ-038 The bench SHALL cover: DECIM=1, SKIP=0, out_ready=1, inData=-5,-4,-3 -> out_data=-5,-4,-3 on consecutive cycles and level never exceeds 1.
REQ-039 The bench SHALL cover: defaults, out_ready=0 for 40 non-skipped cycles -> level reaches 8 after 8 captures, overflow=1 and drop_cnt=2; out_ready then 1 -> first eight captured values drain in order.
REQ-040 The bench SHALL cover: FIFO full, a capture cycle with out_ready=1 -> level stays 8, no overflow, and the new sample lands at the tail.
REQ-041 The bench SHALL cover: overflow=1 with drop_cnt=3, then clear_ovf pulsed on a cycle that also drops -> overflow=1 and drop_cnt=1.
REQ-042 The bench SHALL cover: reset pulsed for one cycle with level=5 -> level=0, out_valid=0 next cycle, and the next capture occurs SKIP cycles after reset deasserts.

Source files
------------

// File: rtl/decimate_buffer_if.sv
// Output stream of the decimating buffer: FWFT head sample plus valid/ready handshake.
// The buffer drives data/valid (master); the consumer drives ready (slave).
interface decimate_buffer_if;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/decimate_buffer.sv
// Discards the first SKIP samples after reset, keeps every DECIM-th sample after that,
// and queues the kept samples in a first-word-fall-through FIFO with sticky overflow tracking.
module decimate_buffer #(
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SKIP  = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [15:0]           inData,
    input  logic                         clear_ovf,
    decimate_buffer_if.master            out_bus,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic [7:0]                   drop_cnt
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam int unsigned PhW  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [PhW-1:0]  PhaseMax = PhW'(DECIM - 1);
    localparam logic [LvlW-1:0] LvlFull  = LvlW'(DEPTH);

    logic                  skipping;
    logic [PhW-1:0]        phase_q;
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [LvlW-1:0]       level_q;
    logic                  overflow_q;
    logic [7:0]            drop_cnt_q;
    logic signed [15:0]    mem_q [DEPTH];

    logic capture;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    // With SKIP == 0 there is nothing to count, so no counter is built at all.
    generate
        if (SKIP == 0) begin : g_no_skip
            assign skipping = 1'b0;
        end else begin : g_skip
            localparam logic [7:0] SkipVal = 8'(SKIP);
            logic [7:0] skip_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    skip_q <= '0;
                end else if (skipping) begin
                    skip_q <= skip_q + 8'd1;
                end
            end

            assign skipping = skip_q < SkipVal;
        end
    endgenerate

    always_comb begin
        capture = !skipping && (phase_q == '0);
        pop     = (level_q != '0) && out_bus.out_ready;
        full    = (level_q == LvlFull);
        // A full FIFO still accepts the sample when the head leaves on the same edge.
        wr_en   = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else if (!skipping) begin
            phase_q <= (phase_q == PhaseMax) ? '0 : phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= inData;
        end
    end

    // A drop on the clearing edge is counted as the first event of the new window.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear_ovf) begin
            overflow_q <= drop;
            drop_cnt_q <= {7'd0, drop};
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        out_bus.out_valid = (level_q != '0);
        out_bus.out_data  = out_bus.out_valid ? mem_q[rd_ptr_q] : '0;
        level             = level_q;
        overflow          = overflow_q;
        drop_cnt          = drop_cnt_q;
    end
endmodule

// File: tb/tb_decimate_buffer.sv
// Bench for decimate_buffer: a default instance and a DECIM=1/SKIP=0 instance share stimulus
// and are compared every cycle against a queue-based model of the kept/dropped sample stream.
module tb_decimate_buffer;
    typedef logic signed [15:0] sample_t;
    typedef sample_t sample_q_t[$];

    localparam int ModelDepth = 8;

    logic    clk = 1'b0;
    logic    reset;
    logic    clear_ovf;
    logic    ready;
    sample_t in_data;

    logic [3:0] level_a;
    logic [3:0] level_b;
    logic       ovf_a;
    logic       ovf_b;
    logic [7:0] dcnt_a;
    logic [7:0] dcnt_b;

    always #5 clk = ~clk;

    decimate_buffer_if bus_a ();
    decimate_buffer_if bus_b ();

    assign bus_a.out_ready = ready;
    assign bus_b.out_ready = ready;

    decimate_buffer dut_a (
        .clk       (clk),
        .reset     (reset),
        .inData    (in_data),
        .clear_ovf (clear_ovf),
        .out_bus   (bus_a.master),
        .level     (level_a),
        .overflow  (ovf_a),
        .drop_cnt  (dcnt_a)
    );

    decimate_buffer #(
        .DECIM (1),
        .DEPTH (8),
        .SKIP  (0)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .inData    (in_data),
        .clear_ovf (clear_ovf),
        .out_bus   (bus_b.master),
        .level     (level_b),
        .overflow  (ovf_b),
        .drop_cnt  (dcnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    sample_q_t q_a;
    sample_q_t q_b;
    int        k_a = 0;
    int        k_b = 0;
    bit        ovf_ma = 1'b0;
    bit        ovf_mb = 1'b0;
    int        dcnt_ma = 0;
    int        dcnt_mb = 0;

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // k counts cycles since reset released; a sample is kept when it is past the skip window
    // and sits on a multiple of the decimation ratio.
    task automatic model_step(input int decim, input int skip, input bit rst, input bit rdy,
                              input bit clr, input sample_t din, inout sample_q_t q,
                              inout int k, inout bit ovf, inout int dcnt);
        bit pop;
        bit cap;
        bit drop;
        if (rst) begin
            q.delete();
            k    = 0;
            ovf  = 1'b0;
            dcnt = 0;
            return;
        end
        pop  = (q.size() > 0) && rdy;
        cap  = (k >= skip) && (((k - skip) % decim) == 0);
        drop = 1'b0;
        k++;
        if (pop) void'(q.pop_front());
        if (cap) begin
            if (q.size() < ModelDepth) q.push_back(din);
            else drop = 1'b1;
        end
        if (clr) begin
            ovf  = drop;
            dcnt = drop ? 1 : 0;
        end else if (drop) begin
            ovf = 1'b1;
            if (dcnt < 255) dcnt++;
        end
    endtask

    task automatic compare_all();
        check_eq("a_valid", 32'(bus_a.out_valid), 32'(q_a.size() != 0));
        check_eq("a_data", 32'(bus_a.out_data), (q_a.size() != 0) ? 32'(q_a[0]) : 0);
        check_eq("a_level", 32'(level_a), q_a.size());
        check_eq("a_overflow", 32'(ovf_a), 32'(ovf_ma));
        check_eq("a_drop_cnt", 32'(dcnt_a), dcnt_ma);
        check_eq("b_valid", 32'(bus_b.out_valid), 32'(q_b.size() != 0));
        check_eq("b_data", 32'(bus_b.out_data), (q_b.size() != 0) ? 32'(q_b[0]) : 0);
        check_eq("b_level", 32'(level_b), q_b.size());
        check_eq("b_overflow", 32'(ovf_b), 32'(ovf_mb));
        check_eq("b_drop_cnt", 32'(dcnt_b), dcnt_mb);
    endtask

    // Inputs are set on the falling edge; the model consumes them at the rising edge and the
    // outputs are checked on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(4, 10, reset, ready, clear_ovf, in_data, q_a, k_a, ovf_ma, dcnt_ma);
        model_step(1, 0, reset, ready, clear_ovf, in_data, q_b, k_b, ovf_mb, dcnt_mb);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        sample_q_t seen;
        sample_q_t caps;
        sample_t   marker;

        reset     = 1'b1;
        clear_ovf = 1'b0;
        ready     = 1'b0;
        in_data   = '0;
        @(negedge clk);
        tick();
        tick();
        check_eq("rst_level", 32'(level_a), 0);
        check_eq("rst_valid", 32'(bus_a.out_valid), 0);
        check_eq("rst_data", 32'(bus_a.out_data), 0);

        // Ramp input, consumer always ready.
        reset = 1'b0;
        ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            in_data = 16'(n);
            tick();
            if (n == 9) check_eq("ramp_pre_valid", 32'(bus_a.out_valid), 0);
            if (n == 10) check_eq("ramp_first", 32'(bus_a.out_data), 10);
            if (bus_a.out_valid) seen.push_back(bus_a.out_data);
        end
        check_eq("ramp_count", seen.size(), 5);
        for (int i = 0; i < seen.size(); i++) begin
            check_eq("ramp_value", 32'(seen[i]), 10 + 4 * i);
        end

        // Pass-through instance on negative samples.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_data = 16'(-5 + i);
            tick();
            check_eq("pass_data", 32'(bus_b.out_data), -5 + i);
            check_eq("pass_level_le1", 32'(level_b <= 4'd1), 1);
        end

        // Stalled consumer: fill, overflow by two, then drain in order.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            in_data = 16'($urandom);
            if (i >= 10 && ((i - 10) % 4) == 0 && caps.size() < 8) caps.push_back(in_data);
            tick();
        end
        check_eq("stall_level", 32'(level_a), 8);
        check_eq("stall_overflow", 32'(ovf_a), 1);
        check_eq("stall_drop_cnt", 32'(dcnt_a), 2);
        ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check_eq("stall_drain", 32'(bus_a.out_data), 32'(caps[j]));
            in_data = 16'($urandom);
            tick();
        end

        // Full FIFO with a pop on a capture edge: the new sample goes to the tail.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 42; i++) begin
            in_data = 16'($urandom);
            tick();
            if (i == 38) check_eq("full_level", 32'(level_a), 8);
        end
        marker  = 16'sh1234;
        in_data = marker;
        ready   = 1'b1;
        tick();
        ready = 1'b0;
        check_eq("full_pop_level", 32'(level_a), 8);
        check_eq("full_pop_overflow", 32'(ovf_a), 0);

        // Three drops, then a clear that lands on a drop edge.
        for (int i = 43; i < 58; i++) begin
            in_data = 16'($urandom);
            tick();
            if (i == 54) check_eq("drop3_cnt", 32'(dcnt_a), 3);
        end
        clear_ovf = 1'b1;
        in_data   = 16'($urandom);
        tick();
        clear_ovf = 1'b0;
        check_eq("clr_drop_overflow", 32'(ovf_a), 1);
        check_eq("clr_drop_cnt", 32'(dcnt_a), 1);
        ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j == 7) check_eq("tail_marker", 32'(bus_a.out_data), 32'(marker));
            in_data = 16'($urandom);
            tick();
        end

        // Long stall saturates the pass-through instance's drop counter.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_data = 16'($urandom);
            tick();
        end
        check_eq("sat_drop_cnt_b", 32'(dcnt_b), 255);
        check_eq("sat_drop_cnt_a", 32'(dcnt_a), 65);

        // Mid-operation reset with five samples queued.
        do_reset();
        for (int i = 0; i < 27; i++) begin
            in_data = 16'($urandom);
            tick();
        end
        check_eq("pre_rst_level", 32'(level_a), 5);
        do_reset();
        check_eq("post_rst_level", 32'(level_a), 0);
        check_eq("post_rst_valid", 32'(bus_a.out_valid), 0);
        for (int i = 0; i < 11; i++) begin
            in_data = 16'($urandom);
            tick();
            if (i == 9) check_eq("reskip_level", 32'(level_a), 0);
            if (i == 10) check_eq("reskip_capture", 32'(level_a), 1);
        end

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 1500; i++) begin
            in_data   = 16'($urandom);
            ready     = ($urandom_range(0, 3) != 0);
            clear_ovf = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
